imem_loader: RTL and testbench
==============================

# imem_loader

Program loader that writes the instruction memory feeding the single-cycle processor's fetch path. It accepts a byte stream over a valid/ready handshake and packs it little-endian into 32-bit instruction words. It writes each word to consecutive word addresses through the memory's write port (`we`/`waddr`/`wdata`). It holds the processor in reset until the requested number of words has been written.

## Interface
Parameters:
- DEPTH, 32: instruction memory size in 32-bit words; legal word counts are 1..DEPTH.
- CNT_W, 6: width of `n_words`; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- n_words  in  CNT_W  number of words to load; sampled with `start`.
- byte_valid  in  1  source has a byte on `byte_data`.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle; handshake = `byte_valid & byte_ready`.
- we  out  1  instruction memory write enable, one-cycle pulse per word.
- waddr  out  32  byte address of the word being written: word_index*4, so memory index = `waddr/4`.
- wdata  out  32  assembled instruction word.
- cpu_hold  out  1  drive into the processor reset; high while memory contents are not valid.
- busy  out  1  high in RECV and WRITE.
- done  out  1  one-cycle pulse after the last word is written.
- err  out  1  one-cycle pulse when `start` arrives with an illegal `n_words`.

## Operation
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - `start=1` with 1 <= `n_words` <= DEPTH: latch the count, clear word index and byte index, assert `cpu_hold`, go to RECV.
  - `start=1` with `n_words`=0 or `n_words` > DEPTH: `err`=1 for the next cycle and stay in IDLE. `cpu_hold` is unchanged.
- RECV:
  - `byte_ready`=1.
  - Each handshake stores `byte_data` into lane byte_index of the word: byte 0 goes to [7:0], byte 3 goes to [31:24].
  - byte_index then increments.
  - On the handshake with byte_index=3, go to WRITE.
  - `byte_valid`=0 stalls RECV indefinitely with no timeout.
- WRITE:
  - Lasts exactly one cycle: `we`=1, `waddr`=word_index*4, `wdata`=assembled word. `byte_ready`=0.
  - If word_index = count-1, go to DONE; otherwise increment word_index, clear byte_index, return to RECV.
- DONE:
  - Lasts one cycle: `done`=1, `cpu_hold`=0, then go to IDLE.
- `start` outside IDLE is ignored; no error is flagged.
- `waddr` is computed from a word index of at most DEPTH-1. Upper bits are zero and there is no wrap-around.
- Reset mid-load:
  - Returns to IDLE at once with `we`=0 and `cpu_hold`=1.
  - Words already written stay in memory; the partial word is discarded.
  - A new `start` is required to reload.

## Timing
- Reset values: state=IDLE, `byte_ready`=0, `we`=0, `waddr`=0, `wdata`=0, `cpu_hold`=1, `busy`=0, `done`=0, `err`=0.
- `cpu_hold` stays 1 after reset until the first successful load completes, and is set again by every accepted `start`.
- Outputs are registered except `byte_ready`, which is decoded from state.
- `start` in cycle t gives state=RECV and `byte_ready`=1 in cycle t+1.
- The fourth byte handshake in cycle t gives `we`=1 in cycle t+1. Memory captures the word on the edge ending t+1.
- With `byte_valid` held high, each word takes 5 cycles (4 RECV + 1 WRITE). N words: `done` appears 5N+1 cycles after `start`.
- `cpu_hold` falls in the same cycle `done` is high. The processor fetches from PC 0 starting the following cycle.
- `err` is high in cycle t+1 for an illegal `start` in cycle t.

## Test plan
- Single word: reset, then `start` with `n_words`=1 and bytes 0x13,0x05,0x50,0x00 streamed back-to-back. Required: `we` pulse with `waddr`=0 and `wdata`=0x00500513; `done` 6 cycles after `start`; `cpu_hold` 1 -> 0.
- Three words with `byte_valid` gaps, holding valid low 2 cycles between bytes. Required: no byte lost; writes at `waddr`=0,4,8 with the correct little-endian words; `byte_ready`=0 during each WRITE cycle.
- Illegal counts: `start` with `n_words`=0, then with 33. Required: `err` pulse each time; state stays IDLE; `we` never asserts; `cpu_hold` stays 1.
- Full memory: `n_words`=32 with data word i = i. Required: last write at `waddr`=124 with `wdata`=31; `done` after 161 cycles; a `start` issued mid-load has no effect.
- Reset mid-load: assert `reset` after 6 bytes of a 4-word load. Required: immediate IDLE, `we`=0, `cpu_hold`=1, `busy`=0. A restarted 1-word load writes `waddr`=0 correctly.
- Fetch integration: load a short program, release `cpu_hold`, run the processor. Required: the processor's fetched instruction matches the memory word at `pc/4` starting at PC 0.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction memory loader: packs a little-endian byte stream into 32-bit words,
// writes them to consecutive word addresses and holds the CPU in reset until done.
module imem_loader #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] n_words,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             we,
  output logic [31:0]      waddr,
  output logic [31:0]      wdata,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {StIdle, StRecv, StWrite, StDone} state_e;

  localparam logic [CNT_W-1:0] MaxCount = CNT_W'(DEPTH);

  state_e           r_state, w_state_d;
  logic [CNT_W-1:0] r_count, w_count_d;
  logic [CNT_W-1:0] r_word_idx, w_word_idx_d;
  logic [1:0]       r_byte_idx, w_byte_idx_d;
  // Lanes 0..2 of the word in progress; lane 3 goes straight into wdata.
  logic [23:0]      r_partial, w_partial_d;

  logic             r_we, w_we_d;
  logic [31:0]      r_waddr, w_waddr_d;
  logic [31:0]      r_wdata, w_wdata_d;
  logic             r_cpu_hold, w_cpu_hold_d;
  logic             r_busy, w_busy_d;
  logic             r_done, w_done_d;
  logic             r_err, w_err_d;

  logic             w_hs;
  logic             w_count_ok;
  logic             w_last_word;

  assign w_hs        = byte_valid & byte_ready;
  assign w_count_ok  = (n_words != '0) && (n_words <= MaxCount);
  assign w_last_word = (r_word_idx == (r_count - 1'b1));

  // Next-state, datapath updates and next values of the registered outputs.
  always_comb begin
    w_state_d    = r_state;
    w_count_d    = r_count;
    w_word_idx_d = r_word_idx;
    w_byte_idx_d = r_byte_idx;
    w_partial_d  = r_partial;
    w_waddr_d    = r_waddr;
    w_wdata_d    = r_wdata;
    w_cpu_hold_d = r_cpu_hold;
    w_err_d      = 1'b0;
    byte_ready   = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (start) begin
          if (w_count_ok) begin
            w_count_d    = n_words;
            w_word_idx_d = '0;
            w_byte_idx_d = '0;
            w_cpu_hold_d = 1'b1;
            w_state_d    = StRecv;
          end else begin
            w_err_d = 1'b1;
          end
        end
      end
      StRecv: begin
        byte_ready = 1'b1;
        if (w_hs) begin
          w_byte_idx_d = r_byte_idx + 2'd1;
          unique case (r_byte_idx)
            2'd0: w_partial_d[7:0]   = byte_data;
            2'd1: w_partial_d[15:8]  = byte_data;
            2'd2: w_partial_d[23:16] = byte_data;
            2'd3: begin
              w_waddr_d = 32'({r_word_idx, 2'b00});
              w_wdata_d = {byte_data, r_partial};
              w_state_d = StWrite;
            end
            default: ;
          endcase
        end
      end
      StWrite: begin
        if (w_last_word) begin
          // Release the CPU in the same cycle done is presented.
          w_cpu_hold_d = 1'b0;
          w_state_d    = StDone;
        end else begin
          w_word_idx_d = r_word_idx + 1'b1;
          w_byte_idx_d = '0;
          w_state_d    = StRecv;
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase

    // Registered outputs reflect the state being entered.
    w_we_d   = (w_state_d == StWrite);
    w_busy_d = (w_state_d == StRecv) || (w_state_d == StWrite);
    w_done_d = (w_state_d == StDone);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_count    <= '0;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_partial  <= '0;
    end else begin
      r_state    <= w_state_d;
      r_count    <= w_count_d;
      r_word_idx <= w_word_idx_d;
      r_byte_idx <= w_byte_idx_d;
      r_partial  <= w_partial_d;
    end
  end

  // Output registers; cpu_hold resets high so the CPU stays parked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_cpu_hold <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_we       <= w_we_d;
      r_waddr    <= w_waddr_d;
      r_wdata    <= w_wdata_d;
      r_cpu_hold <= w_cpu_hold_d;
      r_busy     <= w_busy_d;
      r_done     <= w_done_d;
      r_err      <= w_err_d;
    end
  end

  assign we       = r_we;
  assign waddr    = r_waddr;
  assign wdata    = r_wdata;
  assign cpu_hold = r_cpu_hold;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of load requests, generated programs
// serialized to bytes, write/latency/hold checks and a fetch-side memory check.
module tb_imem_loader;
  localparam int DEPTH = 32;
  localparam int CNT_W = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] n_words;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic             we;
  logic [31:0]      waddr;
  logic [31:0]      wdata;
  logic             cpu_hold;
  logic             busy;
  logic             done;
  logic             err;

  imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .n_words   (n_words),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [31:0] mem [DEPTH];
  logic        exp_hold;

  // mode: 0 back-to-back bytes, 1 two idle cycles after each byte, 2 random valid
  // data: 0 random words, 1 fixed single instruction, 2 word i = i
  typedef struct {
    int   n;
    int   mode;
    int   data;
    logic exp_err;
    int   exp_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] words[$];
    logic [7:0]  bytes[$];
    logic [31:0] w;
    int cyc, nwr, gap, done_cyc;

    if (!v.exp_err) begin
      for (int k = 0; k < v.n; k++) begin
        if (v.data == 1)      w = 32'h0050_0513;
        else if (v.data == 2) w = 32'(k);
        else                  w = $urandom;
        words.push_back(w);
        for (int b = 0; b < 4; b++) bytes.push_back(w[8*b +: 8]);
      end
    end
    for (int k = 0; k < DEPTH; k++) mem[k] = 32'hDEAD_BEEF;

    start   = 1'b1;
    n_words = CNT_W'(v.n);
    tick();
    start = 1'b0;

    if (v.exp_err) begin
      check("err_pulse", {31'd0, err}, 32'd1);
      check("err_idle_busy", {31'd0, busy}, 32'd0);
      check("err_idle_ready", {31'd0, byte_ready}, 32'd0);
      check("err_no_we", {31'd0, we}, 32'd0);
      check("err_hold", {31'd0, cpu_hold}, {31'd0, exp_hold});
      tick();
      check("err_one_cycle", {31'd0, err}, 32'd0);
      check("err_still_idle", {31'd0, busy}, 32'd0);
      return;
    end

    check("start_no_err", {31'd0, err}, 32'd0);
    check("start_ready", {31'd0, byte_ready}, 32'd1);
    check("start_busy", {31'd0, busy}, 32'd1);
    exp_hold = 1'b1;

    cyc      = 1;
    nwr      = 0;
    gap      = 0;
    done_cyc = -1;
    while (cyc < 3000) begin
      if (we) begin
        check("ready_low_in_write", {31'd0, byte_ready}, 32'd0);
        if (nwr < words.size()) begin
          check("waddr", waddr, 32'(nwr * 4));
          check("wdata", wdata, words[nwr]);
        end
        if ((waddr / 4) < DEPTH) mem[waddr / 4] = wdata;
        nwr++;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      check("hold_during_load", {31'd0, cpu_hold}, 32'd1);
      check("no_err_during_load", {31'd0, err}, 32'd0);

      // A start issued mid-load must be ignored.
      start   = (v.data == 2) && (cyc == 50);
      n_words = CNT_W'(1);

      if (bytes.size() > 0) begin
        case (v.mode)
          0:       byte_valid = 1'b1;
          1:       byte_valid = (gap == 0);
          default: byte_valid = 1'($urandom_range(0, 1));
        endcase
      end else begin
        byte_valid = 1'b0;
      end
      byte_data = byte_valid ? bytes[0] : 8'($urandom);
      if (byte_valid && byte_ready) begin
        void'(bytes.pop_front());
        gap = 2;
      end else if (gap > 0) begin
        gap--;
      end
      tick();
      cyc++;
    end
    byte_valid = 1'b0;
    start      = 1'b0;

    if (done_cyc < 0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done, want done within 3000 cycles");
      return;
    end
    check("done_hold_low", {31'd0, cpu_hold}, 32'd0);
    check("done_not_busy", {31'd0, busy}, 32'd0);
    if (v.exp_lat >= 0) check("done_latency", 32'(done_cyc), 32'(v.exp_lat));
    check("write_count", 32'(nwr), 32'(v.n));
    exp_hold = 1'b0;
    tick();
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("hold_stays_low", {31'd0, cpu_hold}, 32'd0);
    // Fetch side: the word at pc/4 must be the program word from PC 0 onward.
    for (int pc = 0; pc < 4 * v.n; pc += 4) check("fetch", mem[pc / 4], words[pc / 4]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    vecs[0] = '{n: 0,  mode: 0, data: 0, exp_err: 1'b1, exp_lat: -1};
    vecs[1] = '{n: 33, mode: 0, data: 0, exp_err: 1'b1, exp_lat: -1};
    vecs[2] = '{n: 1,  mode: 0, data: 1, exp_err: 1'b0, exp_lat: 6};
    vecs[3] = '{n: 3,  mode: 1, data: 0, exp_err: 1'b0, exp_lat: -1};
    vecs[4] = '{n: 32, mode: 0, data: 2, exp_err: 1'b0, exp_lat: 161};
    vecs[5] = '{n: 63, mode: 0, data: 0, exp_err: 1'b1, exp_lat: -1};
    vecs[6] = '{n: 5,  mode: 2, data: 0, exp_err: 1'b0, exp_lat: -1};
    vecs[7] = '{n: 2,  mode: 0, data: 0, exp_err: 1'b0, exp_lat: 11};

    reset      = 1'b1;
    start      = 1'b0;
    n_words    = '0;
    byte_valid = 1'b0;
    byte_data  = '0;
    exp_hold   = 1'b1;
    #3;
    check("rst_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_waddr", waddr, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset in the middle of a 4-word load, after 6 accepted bytes.
    start   = 1'b1;
    n_words = CNT_W'(4);
    tick();
    start = 1'b0;
    hs    = 0;
    for (int c = 0; c < 100 && hs < 6; c++) begin
      byte_valid = 1'b1;
      byte_data  = 8'($urandom);
      if (byte_ready) hs++;
      tick();
    end
    byte_valid = 1'b0;
    check("mid_busy_before_reset", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_we", {31'd0, we}, 32'd0);
    check("mid_rst_hold", {31'd0, cpu_hold}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_ready", {31'd0, byte_ready}, 32'd0);
    tick();
    reset    = 1'b0;
    exp_hold = 1'b1;
    tick();
    check("mid_idle_after_reset", {31'd0, busy}, 32'd0);
    run_vec('{n: 1, mode: 0, data: 0, exp_err: 1'b0, exp_lat: 6});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
